// File: rtl/dvp_tx_if.sv
// Pixel-stream input and DVP byte-stream output bundle for dvp_tx.
// slave = the transmitter; master = the pixel source / DVP observer.
interface dvp_tx_if;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  dvp_pixel;
  logic        dvp_href;
  logic        dvp_vsync;
  logic        underrun;
  logic        sync_err;

  modport master (
    output pix_data, pix_sof, pix_valid,
    input  pix_ready, dvp_pixel, dvp_href, dvp_vsync, underrun, sync_err
  );

  modport slave (
    input  pix_data, pix_sof, pix_valid,
    output pix_ready, dvp_pixel, dvp_href, dvp_vsync, underrun, sync_err
  );
endinterface

// File: rtl/dvp_tx.sv
// DVP source: RGB888 valid/ready stream in, RGB565 bytes (high byte first) out,
// with generated vsync/href frame timing. All outputs are registered.
module dvp_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned VBP_LINES   = 17,
  parameter int unsigned VFP_LINES   = 10
) (
  input  logic     dvp_clk,
  input  logic     rst,
  input  logic     en,
  dvp_tx_if.slave  bus
);

  localparam int unsigned LineLen = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned Max01   = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int unsigned Max23   = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int unsigned MaxLines = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned HW = $clog2(LineLen);
  localparam int unsigned VW = $clog2(MaxLines + 1);

  localparam logic [HW-1:0] HLast    = HW'(LineLen - 1);
  localparam logic [HW-1:0] HActEnd  = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0] HActOdd  = HW'(2 * H_ACTIVE - 1);
  localparam logic [VW-1:0] VsLast   = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VbpLast  = VW'((VBP_LINES > 0) ? VBP_LINES - 1 : 0);
  localparam logic [VW-1:0] VactLast = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VfpLast  = VW'(VFP_LINES - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [VW-1:0] v_last;
  logic          line_end, state_end, pre_active;
  logic [7:0]    pixel_q, pixel_d, lo_q, lo_d;
  logic          href_q, href_d, vsync_q, vsync_d, ready_q, ready_d;
  logic          underrun_q, underrun_d, sync_err_q, sync_err_d, first_q, first_d;
  logic          unused_lsb;

  assign unused_lsb = ^{bus.pix_data[18:16], bus.pix_data[9:8], bus.pix_data[2:0]};

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    line_end = (h_q == HLast);
    case (state_q)
      StVsync:  v_last = VsLast;
      StVbp:    v_last = VbpLast;
      StActive: v_last = VactLast;
      StVfp:    v_last = VfpLast;
      default:  v_last = '0;
    endcase
    state_end = line_end && (v_q == v_last);

    if (state_q == StIdle) begin
      if (en) state_d = StVsync;
    end else begin
      h_d = line_end ? '0 : h_q + 1'b1;
      if (line_end) v_d = state_end ? '0 : v_q + 1'b1;
      if (state_end) begin
        case (state_q)
          StVsync:  state_d = (VBP_LINES > 0) ? StVbp : StActive;
          StVbp:    state_d = StActive;
          StActive: state_d = StVfp;
          StVfp:    state_d = en ? StVsync : StIdle;
          default:  state_d = StIdle;
        endcase
      end
    end
  end

  // Outputs are derived from the next position so they line up with it once registered.
  always_comb begin
    pre_active = (h_d == HLast) &&
                 ((state_d == StVbp && v_d == VbpLast) ||
                  (VBP_LINES == 0 && state_d == StVsync && v_d == VsLast) ||
                  (state_d == StActive && v_d != VactLast));
    ready_d    = pre_active || (state_d == StActive && h_d[0] && h_d < HActOdd);
    href_d     = (state_d == StActive) && (h_d < HActEnd);
    vsync_d    = (state_d == StVsync);
    underrun_d = ready_q && !bus.pix_valid;
    sync_err_d = ready_q && bus.pix_valid && (bus.pix_sof != first_q);

    first_d = first_q;
    if (ready_q) first_d = 1'b0;
    else if (state_d == StVsync) first_d = 1'b1;

    lo_d    = lo_q;
    pixel_d = 8'h00;
    if (ready_q) begin
      pixel_d = bus.pix_valid ? {bus.pix_data[23:19], bus.pix_data[15:13]} : 8'h00;
      lo_d    = bus.pix_valid ? {bus.pix_data[12:10], bus.pix_data[7:3]} : 8'h00;
    end else if (href_d) begin
      pixel_d = lo_q;
    end
  end

  always_ff @(posedge dvp_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      h_q        <= '0;
      v_q        <= '0;
      pixel_q    <= 8'h00;
      lo_q       <= 8'h00;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      pixel_q    <= pixel_d;
      lo_q       <= lo_d;
      href_q     <= href_d;
      vsync_q    <= vsync_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
      first_q    <= first_d;
    end
  end

  assign bus.pix_ready = ready_q;
  assign bus.dvp_pixel = pixel_q;
  assign bus.dvp_href  = href_q;
  assign bus.dvp_vsync = vsync_q;
  assign bus.underrun  = underrun_q;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Bench for dvp_tx: frame-position model checked every cycle, plus literal
// expectations for timing windows, packed bytes, underrun, sof errors, en and reset.
module tb_dvp_tx;
  localparam int HA = 4, HB = 3, VA = 2, VS = 1, VB = 1, VF = 1;
  localparam int LL = 2 * HA + HB;
  localparam int FL = (VS + VB + VA + VF) * LL;
  localparam int ACT0 = VS + VB;

  logic dvp_clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  dvp_tx_if bus();

  dvp_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
           .VBP_LINES(VB), .VFP_LINES(VF)) dut (
    .dvp_clk (dvp_clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus)
  );

  always #5 dvp_clk = ~dvp_clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [23:0] d_tbl[8];
  bit          v_tbl[8], s_tbl[8];

  // Model state: running flag and position within the frame.
  bit          m_run = 0;
  int          m_fc = 0;
  bit          m_und = 0, m_serr = 0;
  bit          rec_v[8];
  logic [23:0] rec_d[8];

  logic [7:0] px_fc[FL];
  bit         vs_fc[FL], hr_fc[FL], rd_fc[FL];
  int         und_cnt = 0, serr_cnt = 0;

  function automatic bit is_byte(int p);
    return (p / LL >= ACT0) && (p / LL < ACT0 + VA) && (p % LL < 2 * HA);
  endfunction
  function automatic int slot_of(int p);
    return (p / LL - ACT0) * HA + (p % LL) / 2;
  endfunction
  function automatic bit model_ready();
    return m_run && (m_fc + 1 < FL) && is_byte(m_fc + 1) && ((m_fc + 1) % LL) % 2 == 0;
  endfunction
  function automatic int b0(logic [23:0] p);
    int r = int'(p[23:16]);
    int g = int'(p[15:8]);
    return ((r >> 3) << 3) | (g >> 5);
  endfunction
  function automatic int b1(logic [23:0] p);
    int g = int'(p[15:8]);
    int b = int'(p[7:0]);
    return (((g >> 2) & 7) << 5) | (b >> 3);
  endfunction

  initial begin
    bit rdy;
    int s, e_px;
    bit e_vs, e_hr, e_rd;
    forever begin
      @(posedge dvp_clk);
      if (rst) begin
        m_run = 0; m_fc = 0; m_und = 0; m_serr = 0;
      end else begin
        rdy = model_ready();
        m_und = 0; m_serr = 0;
        if (rdy) begin
          s = slot_of(m_fc + 1);
          rec_v[s] = bus.pix_valid;
          rec_d[s] = bus.pix_data;
          m_und  = !bus.pix_valid;
          m_serr = bus.pix_valid && (bus.pix_sof != (s == 0));
        end
        if (!m_run) begin
          if (en) begin m_run = 1; m_fc = 0; end
        end else if (m_fc == FL - 1) begin
          if (en) m_fc = 0; else m_run = 0;
        end else begin
          m_fc++;
        end
      end
      #1;
      e_vs = m_run && (m_fc / LL < VS);
      e_hr = m_run && is_byte(m_fc);
      e_rd = model_ready();
      e_px = 0;
      if (e_hr) begin
        s = slot_of(m_fc);
        if (rec_v[s]) e_px = (m_fc % LL) % 2 == 0 ? b0(rec_d[s]) : b1(rec_d[s]);
      end
      chk("vsync", bus.dvp_vsync, e_vs);
      chk("href", bus.dvp_href, e_hr);
      chk("pixel", bus.dvp_pixel, e_px);
      chk("ready", bus.pix_ready, e_rd);
      chk("underrun", bus.underrun, m_und);
      chk("sync_err", bus.sync_err, m_serr);
      if (m_run) begin
        px_fc[m_fc] = bus.dvp_pixel;
        vs_fc[m_fc] = bus.dvp_vsync;
        hr_fc[m_fc] = bus.dvp_href;
        rd_fc[m_fc] = bus.pix_ready;
      end
      und_cnt  += int'(bus.underrun);
      serr_cnt += int'(bus.sync_err);
    end
  end

  // Source presents the pixel for whichever slot the next ready belongs to.
  initial begin
    int s;
    forever begin
      @(negedge dvp_clk);
      s = model_ready() ? slot_of(m_fc + 1) : 0;
      bus.pix_data  = d_tbl[s];
      bus.pix_valid = v_tbl[s];
      bus.pix_sof   = s_tbl[s];
    end
  end

  task automatic wait_fc(input int f, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge dvp_clk);
      if (m_run && m_fc == f) break;
    end
    chk("wait_fc", m_fc, f);
  endtask

  initial begin
    int nv, nh, nr;
    d_tbl[0] = 24'hFF8040; d_tbl[1] = 24'h123456; d_tbl[2] = 24'hFFFFFF; d_tbl[3] = 24'h00FF00;
    d_tbl[4] = 24'hA5C33C; d_tbl[5] = 24'h0F1E2D; d_tbl[6] = 24'h808080; d_tbl[7] = 24'h7F7F7F;
    for (int i = 0; i < 8; i++) begin v_tbl[i] = 1; s_tbl[i] = (i == 0); end
    bus.pix_data = '0; bus.pix_valid = 0; bus.pix_sof = 0;

    repeat (3) @(negedge dvp_clk);
    chk("rst_pixel", bus.dvp_pixel, 0);
    chk("rst_vsync", bus.dvp_vsync, 0);
    chk("rst_ready", bus.pix_ready, 0);
    rst = 0; en = 1;

    // Frame 0: timing windows and packed bytes.
    wait_fc(54, 100);
    nv = 0; nh = 0; nr = 0;
    for (int i = 0; i < FL; i++) begin nv += vs_fc[i]; nh += hr_fc[i]; nr += rd_fc[i]; end
    chk("vsync_cycles", nv, 11);
    chk("vsync_end", {vs_fc[10], vs_fc[11]}, 2'b10);
    chk("href_cycles", nh, 16);
    chk("href_edges0", {hr_fc[21], hr_fc[22], hr_fc[29], hr_fc[30]}, 4'b0110);
    chk("href_edges1", {hr_fc[32], hr_fc[33], hr_fc[40], hr_fc[41]}, 4'b0110);
    chk("ready_count", nr, 8);
    chk("ready_first", {rd_fc[21], rd_fc[22], rd_fc[32]}, 3'b101);
    chk("bytes_ff8040", {px_fc[22], px_fc[23]}, 16'hFC08);
    chk("bytes_123456", {px_fc[24], px_fc[25]}, 16'h11AA);
    chk("idle_after_href", px_fc[30], 0);

    // Frame 1 repeats with period 55.
    @(negedge dvp_clk);
    chk("repeat_vsync", bus.dvp_vsync, 1);
    wait_fc(54, 100);

    // Underrun on slot 2 (third slot of line 0).
    v_tbl[2] = 0; und_cnt = 0;
    wait_fc(54, 100);
    chk("underrun_pulses", und_cnt, 1);
    chk("underrun_bytes", {px_fc[26], px_fc[27]}, 16'h0000);
    chk("after_underrun", {px_fc[28], px_fc[29]}, 16'h07E0);
    chk("before_underrun", {px_fc[24], px_fc[25]}, 16'h11AA);
    v_tbl[2] = 1;

    // sof on second pixel instead of first.
    s_tbl[0] = 0; s_tbl[1] = 1; serr_cnt = 0;
    wait_fc(54, 100);
    chk("sof_err_pulses", serr_cnt, 2);
    chk("sof_bytes", {px_fc[22], px_fc[23], px_fc[24], px_fc[25]}, 32'hFC0811AA);
    s_tbl[0] = 1; s_tbl[1] = 0;

    // en dropped mid-ACTIVE: frame completes, then idle.
    wait_fc(25, 100);
    en = 0;
    wait_fc(33, 100);
    chk("en_low_href", bus.dvp_href, 1);
    wait_fc(54, 100);
    repeat (5) @(negedge dvp_clk);
    chk("idle_outputs", {bus.dvp_vsync, bus.dvp_href, bus.pix_ready, bus.dvp_pixel}, 0);
    en = 1;
    @(negedge dvp_clk);
    chk("restart_vsync", bus.dvp_vsync, 1);

    // Asynchronous reset inside line 1 href window.
    wait_fc(35, 100);
    chk("pre_rst_href", bus.dvp_href, 1);
    rst = 1;
    #1;
    chk("rst_async", {bus.dvp_vsync, bus.dvp_href, bus.pix_ready, bus.dvp_pixel,
                      bus.underrun, bus.sync_err}, 0);
    repeat (2) @(negedge dvp_clk);
    rst = 0;
    @(negedge dvp_clk);
    chk("post_rst_vsync", bus.dvp_vsync, 1);
    wait_fc(54, 100);
    chk("post_rst_bytes", {px_fc[22], px_fc[23]}, 16'hFC08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
